cpu_controller: RTL and testbench

Instruction register, decoder and Moore state machine that issues the per-cycle control strobes consumed by `datapath` (`readnum`, `vsel`, `loada`, `loadb`, `shift`, `asel`, `bsel`, `ALUop`, `loadc`, `loads`, `writenum`, `write`). It executes one 16-bit instruction per `s` pulse, signals idle on `w`, and supplies the sign-extended immediate that the CPU top routes to `datapath_in`.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/instr_decoder.sv | 43 ++++
 rtl/cpu_controller.sv | 126 ++++++++++++
 tb/tb_cpu_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU controller: FSM states, instruction classes,
// opcode/op encodings and instruction-word field positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_DECODE,
        ST_WRITE_IMM,
        ST_GET_A,
        ST_GET_B,
        ST_EXEC,
        ST_WRITE_REG
    } state_t;

    typedef enum logic [2:0] {
        CLS_UNDEF,
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_ALU,
        CLS_CMP
    } instr_class_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam int OPCODE_LSB = 13;
    localparam int OP_LSB     = 11;
    localparam int RN_LSB     = 8;
    localparam int RD_LSB     = 5;
    localparam int SH_LSB     = 3;
    localparam int RM_LSB     = 0;
    localparam int IMM8_MSB   = 7;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits IR into register/shift fields,
// sign-extends imm8 and classifies the instruction for the controller FSM.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0]   ir,
    output logic [2:0]    rn,
    output logic [2:0]    rd,
    output logic [2:0]    rm,
    output logic [1:0]    op,
    output logic [1:0]    sh,
    output logic [15:0]   sximm8,
    output instr_class_t  instr_class
);

    logic [2:0] opcode;

    assign opcode = ir[OPCODE_LSB +: 3];
    assign op     = ir[OP_LSB +: 2];
    assign rn     = ir[RN_LSB +: 3];
    assign rd     = ir[RD_LSB +: 3];
    assign sh     = ir[SH_LSB +: 2];
    assign rm     = ir[RM_LSB +: 3];
    assign sximm8 = {{8{ir[IMM8_MSB]}}, ir[IMM8_MSB:0]};

    // MVN shares the ALU class; the FSM tells it apart by op to skip GET_A.
    always_comb begin
        instr_class = CLS_UNDEF;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)
                instr_class = CLS_MOV_IMM;
            else if (op == OP_MOV_REG)
                instr_class = CLS_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD, OP_AND, OP_MVN: instr_class = CLS_ALU;
                OP_CMP:                 instr_class = CLS_CMP;
                default:                instr_class = CLS_UNDEF;
            endcase
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore FSM that sequences one instruction per 's'
// pulse and drives the datapath control strobes from the current state only.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [15:0] sximm8,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic [1:0]  shift,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads,
    output logic        write
);

    state_t       state, next_state;
    logic [15:0]  ir;
    logic [2:0]   rn, rd, rm;
    logic [1:0]   op, sh;
    instr_class_t instr_class;

    instr_decoder u_decoder (
        .ir          (ir),
        .rn          (rn),
        .rd          (rd),
        .rm          (rm),
        .op          (op),
        .sh          (sh),
        .sximm8      (sximm8),
        .instr_class (instr_class)
    );

    // IR only accepts a new word while idle, so DECODE sees a word loaded on the start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ir <= '0;
        else if (load && state == ST_WAIT)
            ir <= in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_WAIT;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        w          = 1'b0;
        readnum    = 3'd0;
        writenum   = 3'd0;
        vsel       = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        shift      = 2'b00;
        asel       = 1'b0;
        bsel       = 1'b0;
        ALUop      = 2'b00;
        loadc      = 1'b0;
        loads      = 1'b0;
        write      = 1'b0;

        case (state)
            ST_WAIT: begin
                w = 1'b1;
                if (s)
                    next_state = ST_DECODE;
            end
            ST_DECODE: begin
                case (instr_class)
                    CLS_MOV_IMM: next_state = ST_WRITE_IMM;
                    CLS_MOV_REG: next_state = ST_GET_B;
                    CLS_ALU:     next_state = (op == OP_MVN) ? ST_GET_B : ST_GET_A;
                    CLS_CMP:     next_state = ST_GET_A;
                    default:     next_state = ST_WAIT;
                endcase
            end
            ST_WRITE_IMM: begin
                writenum   = rn;
                vsel       = 1'b1;
                write      = 1'b1;
                next_state = ST_WAIT;
            end
            ST_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = ST_GET_B;
            end
            ST_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                shift      = sh;
                next_state = ST_EXEC;
            end
            // MOV reg passes the shifted B operand through an ADD with A forced to zero.
            ST_EXEC: begin
                shift      = sh;
                ALUop      = (instr_class == CLS_MOV_REG) ? 2'b00 : op;
                asel       = (instr_class == CLS_MOV_REG);
                loadc      = (instr_class != CLS_CMP);
                loads      = (instr_class == CLS_CMP);
                next_state = (instr_class == CLS_CMP) ? ST_WAIT : ST_WRITE_REG;
            end
            ST_WRITE_REG: begin
                writenum   = rd;
                vsel       = 1'b0;
                write      = 1'b1;
                next_state = ST_WAIT;
            end
            default: next_state = ST_WAIT;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: a per-cycle scoreboard built from an
// instruction-level model, a vector table of instructions, and corner-case sequences.
module tb_cpu_controller;

    logic        clk;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic [15:0] sximm8;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic        write;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        vsel;
        logic        loada;
        logic        loadb;
        logic [1:0]  shift;
        logic        asel;
        logic        bsel;
        logic [1:0]  ALUop;
        logic        loadc;
        logic        loads;
        logic        write;
        logic [15:0] sximm8;
    } ctrl_t;

    typedef struct {
        logic [15:0] word;
        int          latency;
        logic        writes;
        logic [2:0]  dest;
    } vec_t;

    cpu_controller dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .load     (load),
        .in       (in),
        .w        (w),
        .sximm8   (sximm8),
        .readnum  (readnum),
        .writenum (writenum),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .shift    (shift),
        .asel     (asel),
        .bsel     (bsel),
        .ALUop    (ALUop),
        .loadc    (loadc),
        .loads    (loads),
        .write    (write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctrl_t      exp_q[$];
    int         checks = 0;
    int         passed = 0;
    int         last_latency;
    logic       last_writes;
    logic [2:0] last_dest;
    vec_t       vecs[10];

    function automatic ctrl_t actual_ctrl();
        ctrl_t c;
        c.w        = w;
        c.readnum  = readnum;
        c.writenum = writenum;
        c.vsel     = vsel;
        c.loada    = loada;
        c.loadb    = loadb;
        c.shift    = shift;
        c.asel     = asel;
        c.bsel     = bsel;
        c.ALUop    = ALUop;
        c.loadc    = loadc;
        c.loads    = loads;
        c.write    = write;
        c.sximm8   = sximm8;
        return c;
    endfunction

    function automatic ctrl_t idle_ctrl(input logic [15:0] sx);
        ctrl_t c;
        c        = '0;
        c.w      = 1'b1;
        c.sximm8 = sx;
        return c;
    endfunction

    // Reference model: expected control word for every cycle after the start edge.
    function automatic void push_expected(input logic [15:0] word);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        logic       mov_imm, mov_reg, alu, cmp, mvn;
        ctrl_t      base, c;
        opc     = word[15:13];
        op      = word[12:11];
        rn      = word[10:8];
        rd      = word[7:5];
        sh      = word[4:3];
        rm      = word[2:0];
        mov_imm = (opc == 3'b110) && (op == 2'b10);
        mov_reg = (opc == 3'b110) && (op == 2'b00);
        alu     = (opc == 3'b101);
        cmp     = alu && (op == 2'b01);
        mvn     = alu && (op == 2'b11);
        base        = '0;
        base.sximm8 = {{8{word[7]}}, word[7:0]};
        exp_q.push_back(base);
        if (mov_imm) begin
            c = base; c.writenum = rn; c.vsel = 1'b1; c.write = 1'b1;
            exp_q.push_back(c);
        end else if (mov_reg || alu) begin
            if (!(mov_reg || mvn)) begin
                c = base; c.readnum = rn; c.loada = 1'b1;
                exp_q.push_back(c);
            end
            c = base; c.readnum = rm; c.loadb = 1'b1; c.shift = sh;
            exp_q.push_back(c);
            c = base; c.shift = sh; c.ALUop = alu ? op : 2'b00; c.asel = mov_reg;
            c.loadc = !cmp; c.loads = cmp;
            exp_q.push_back(c);
            if (!cmp) begin
                c = base; c.writenum = rd; c.write = 1'b1;
                exp_q.push_back(c);
            end
        end
        exp_q.push_back(idle_ctrl(base.sximm8));
    endfunction

    task automatic checkOutput(input string tag, input ctrl_t expected);
        ctrl_t act;
        act = actual_ctrl();
        checks++;
        if (act === expected)
            passed++;
        else
            $display("[TB] FAIL %s: got %h expected %h", tag, act, expected);
    endtask

    task automatic checkValue(input string tag, input int act, input int expected);
        checks++;
        if (act == expected)
            passed++;
        else
            $display("[TB] FAIL %s: got %0d expected %0d", tag, act, expected);
    endtask

    // Starts 'word' with load+s on the same edge. repeat_n=2 keeps s high so the
    // same IR runs twice back to back; junk_at/reset_at inject a load of 0xFFFF or
    // an asynchronous reset after that many edges (0 disables).
    task automatic applyStimulus(input logic [15:0] word, input int repeat_n,
                                 input int junk_at, input int reset_at);
        int k;
        int hold_edges;
        @(negedge clk);
        in   = word;
        load = 1'b1;
        s    = 1'b1;
        push_expected(word);
        hold_edges = 1;
        if (repeat_n == 2) begin
            hold_edges = exp_q.size() + 1;
            push_expected(word);
        end
        last_latency = -1;
        last_writes  = 1'b0;
        last_dest    = 3'd0;
        k = 0;
        while (exp_q.size() > 0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (k >= hold_edges) s = 1'b0;
            if (k == 1) load = 1'b0;
            if (k == junk_at) begin
                in   = 16'hFFFF;
                load = 1'b1;
            end
            if (k == junk_at + 1) load = 1'b0;
            checkOutput($sformatf("cycle %0d of %h", k, word), exp_q.pop_front());
            if (write) begin
                last_writes = 1'b1;
                last_dest   = writenum;
            end
            if (w && last_latency < 0) last_latency = k;
            if (k == reset_at) begin
                #2 reset = 1'b1;
                #1;
                checkOutput("async reset mid-instruction", idle_ctrl(16'h0000));
                exp_q.delete();
            end
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("[TB] FAIL timeout on %h: %0d expected cycles not reached", word, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        vecs[0] = '{16'hD1FE, 3, 1'b1, 3'd1};
        vecs[1] = '{16'hA049, 6, 1'b1, 3'd2};
        vecs[2] = '{16'hA801, 5, 1'b0, 3'd0};
        vecs[3] = '{16'hB861, 5, 1'b1, 3'd3};
        vecs[4] = '{16'hC0B3, 5, 1'b1, 3'd5};
        vecs[5] = '{16'hB4DF, 6, 1'b1, 3'd6};
        vecs[6] = '{16'hD77F, 3, 1'b1, 3'd7};
        vecs[7] = '{16'h0000, 2, 1'b0, 3'd0};
        vecs[8] = '{16'hC800, 2, 1'b0, 3'd0};
        vecs[9] = '{16'hE5A5, 2, 1'b0, 3'd0};

        reset = 1'b1;
        s     = 1'b0;
        load  = 1'b0;
        in    = 16'h0000;
        #12;
        checkOutput("reset state", idle_ctrl(16'h0000));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("idle cycle %0d", i), idle_ctrl(16'h0000));
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].word, 1, 0, 0);
            checkValue($sformatf("latency %h", vecs[i].word), last_latency, vecs[i].latency);
            checkValue($sformatf("write seen %h", vecs[i].word), int'(last_writes), int'(vecs[i].writes));
            if (vecs[i].writes)
                checkValue($sformatf("dest reg %h", vecs[i].word), int'(last_dest), int'(vecs[i].dest));
        end

        applyStimulus(16'hA049, 1, 3, 0);
        checkValue("latency after ignored load", last_latency, 6);
        checkValue("dest after ignored load", int'(last_dest), 2);

        applyStimulus(16'hA049, 1, 0, 4);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("idle after reset release", idle_ctrl(16'h0000));

        applyStimulus(16'hD205, 2, 0, 0);
        checkValue("back-to-back dest", int'(last_dest), 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
